tap_word_fifo: RTL and testbench



---
 rtl/tap_pkg.sv | 15 +
 rtl/tap_fifo_mem.sv | 26 ++
 rtl/tap_word_fifo.sv | 98 +++++++++
 tb/tb_tap_word_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared constants for the JTAG TAP user-register path: decoder word width,
// default word-FIFO depth and the occupancy-counter width helper.
package tap_pkg;

  localparam int USER_DR_WIDTH   = 32;
  localparam int USER_FIFO_DEPTH = 16;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int USER_FIFO_LEVEL_W = level_w(USER_FIFO_DEPTH);

endpackage

// File: rtl/tap_fifo_mem.sv
// Register array for the TAP word FIFO: one synchronous write port and one
// asynchronous read port so the head word can be presented show-ahead.
module tap_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tap_word_fifo.sv
// First-word-fall-through FIFO for decoded USER-register words in the tck
// domain, with explicit occupancy counter and a sticky overflow flag.
module tap_word_fifo
  import tap_pkg::*;
#(
  parameter int DATA_WIDTH = USER_DR_WIDTH,
  parameter int DEPTH      = USER_FIFO_DEPTH
) (
  input  logic                        tck,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        empty,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic full_w, empty_w;
  logic push, pop;

  // Status decoded only from registered occupancy; no path from in_valid/out_ready.
  assign full_w  = (level_q == LW'(DEPTH));
  assign empty_w = (level_q == '0);

  assign pop  = !empty_w && out_ready;
  assign push = in_valid && (!full_w || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A push refused at full is a lost JTAG command; remember it until reset.
    if (in_valid && full_w && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge tck) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  tap_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (tck),
    .we_i    (push && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_data)
  );

  assign out_valid = !empty_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = ovf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_tap_word_fifo.sv
// Directed bench for tap_word_fifo: vector table for basic push/pop cases,
// then hand-written sequences for fill/overflow, full push+pop, wrap and reset.
module tb_tap_word_fifo;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int LW = $clog2(DP + 1);

  logic          tck = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          overflow;

  int n_total = 0;
  int n_pass  = 0;

  always #5 tck = ~tck;

  tap_word_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .tck       (tck),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  typedef struct {
    logic          rst;
    logic          iv;
    logic [DW-1:0] d;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic [LW-1:0] el;
    logic          ef;
    logic          ee;
    logic          eo;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply inputs, take one rising edge, return #1 later for sampling.
  task automatic cyc(input logic r, input logic iv, input logic [DW-1:0] d, input logic rdy);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    @(posedge tck);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //               rst  iv   data          rdy  ev   edata         lvl  full empty ovf
    vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h11111111, 1'b1, 1'b1, 32'h11111111, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1, 32'h22222222, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 32'h22222222, 5'd2, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h33333333, 5'd1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 1'b1, 1'b0};

    #2;
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].rst, vt[i].iv, vt[i].d, vt[i].rdy);
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d level", i),     32'(level),     32'(vt[i].el));
      chk($sformatf("vec%0d full", i),      32'(full),      32'(vt[i].ef));
      chk($sformatf("vec%0d empty", i),     32'(empty),     32'(vt[i].ee));
      chk($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vt[i].eo));
      if (vt[i].ev) chk($sformatf("vec%0d out_data", i), out_data, vt[i].ed);
    end

    // Fill to full, drop the 17th word, drain in order.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(1'b0, 1'b1, DW'(i), 1'b0);
      if (i == 15) begin
        chk("fill full@16", 32'(full), 32'd1);
        chk("fill level@16", 32'(level), 32'd16);
        chk("fill ovf@16", 32'(overflow), 32'd0);
      end
    end
    chk("drop level", 32'(level), 32'd16);
    chk("drop ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d data", i), out_data, DW'(i));
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    chk("drain empty", 32'(empty), 32'd1);
    chk("drain ovf sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 32'h100 + DW'(i), 1'b0);
    cyc(1'b0, 1'b1, 32'hAA, 1'b1);
    chk("fpp level", 32'(level), 32'd16);
    chk("fpp full", 32'(full), 32'd1);
    chk("fpp ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("fpp drain%0d", i), out_data, 32'h100 + DW'(i));
      cyc(1'b0, 1'b0, '0, 1'b1);
    end
    chk("fpp last", out_data, 32'hAA);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("fpp empty", 32'(empty), 32'd1);

    // Streaming across several pointer wraps with a pop every cycle.
    do_reset();
    begin
      int max_lvl = 0;
      for (int i = 0; i < 40; i++) begin
        if (i > 0) chk($sformatf("wrap%0d data", i), out_data, 32'h200 + DW'(i - 1));
        cyc(1'b0, 1'b1, 32'h200 + DW'(i), 1'b1);
        if (int'(level) > max_lvl) max_lvl = int'(level);
      end
      chk("wrap max level", 32'(max_lvl), 32'd1);
      chk("wrap tail", out_data, 32'h200 + 32'd39);
      cyc(1'b0, 1'b0, '0, 1'b1);
      chk("wrap empty", 32'(empty), 32'd1);
    end

    // Mid-stream reset with a concurrent push; overflow primed first.
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 32'h300 + DW'(i), 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("mr pre level", 32'(level), 32'd5);
    chk("mr pre ovf", 32'(overflow), 32'd1);
    cyc(1'b1, 1'b1, 32'hBAD, 1'b1);
    chk("mr level", 32'(level), 32'd0);
    chk("mr empty", 32'(empty), 32'd1);
    chk("mr ovf", 32'(overflow), 32'd0);
    chk("mr out_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b1, 32'h5A5A, 1'b0);
    chk("mr next level", 32'(level), 32'd1);
    chk("mr next data", out_data, 32'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
